// File: rtl/preg_pkg.sv
// rtl/preg_pkg.sv - state encoding and helpers for the skid pipeline stage register
package preg_pkg;

    typedef enum logic [1:0] {
        PREG_EMPTY = 2'd0,
        PREG_FULL  = 2'd1,
        PREG_SKID  = 2'd2
    } preg_state_t;

    // The unused encoding counts as empty, matching how the next-state logic treats it.
    function automatic logic [1:0] preg_occupancy(input preg_state_t s);
        case (s)
            PREG_FULL: preg_occupancy = 2'd1;
            PREG_SKID: preg_occupancy = 2'd2;
            default:   preg_occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/preg_skid_stage.sv
// rtl/preg_skid_stage.sv - pipeline stage register with registered upstream ready and 2-entry skid
module preg_skid_stage
    import preg_pkg::*;
#(
    parameter int PAYLOAD_W      = 256,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [PAYLOAD_W-1:0] i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [PAYLOAD_W-1:0] o_data,
    output logic [1:0]           o_occupancy
);

    preg_state_t          state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic                 in_fire;
    logic                 out_fire;

    assign o_valid     = (state_q == PREG_FULL) || (state_q == PREG_SKID);
    assign o_ready     = (state_q != PREG_SKID);
    assign o_occupancy = preg_occupancy(state_q);
    assign o_data      = main_q;

    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = PREG_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                PREG_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = i_data;
                    end else if (in_fire) begin
                        state_d = PREG_SKID;
                        skid_d  = i_data;
                    end else if (out_fire) begin
                        state_d = PREG_EMPTY;
                    end
                end
                PREG_SKID: begin
                    // Upstream is blocked here, so only the drain path exists.
                    if (out_fire) begin
                        state_d = PREG_FULL;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = PREG_EMPTY;
                    if (in_fire) begin
                        state_d = PREG_FULL;
                        main_d  = i_data;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= PREG_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            main_q <= '0;
        end else begin
            main_q <= main_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            skid_q <= '0;
        end else begin
            skid_q <= skid_d;
        end
    end

endmodule

// File: tb/tb_preg_skid_stage.sv
// tb/tb_preg_skid_stage.sv - directed and randomized bench for preg_skid_stage against a queue model
module tb_preg_skid_stage;

    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_arst;
    logic         i_flush;
    logic         i_valid;
    logic [W-1:0] i_data;
    logic         i_ready;

    logic         a_ready, a_valid, b_ready, b_valid;
    logic [W-1:0] a_data, b_data;
    logic [1:0]   a_occ, b_occ;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] model_q[$];

    always #5 i_clk = ~i_clk;

    preg_skid_stage #(.PAYLOAD_W(W), .CLEAR_ON_FLUSH(1'b1)) dut_clr (
        .i_clk(i_clk), .i_arst(i_arst), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(a_ready), .i_data(i_data),
        .o_valid(a_valid), .i_ready(i_ready), .o_data(a_data),
        .o_occupancy(a_occ)
    );

    preg_skid_stage #(.PAYLOAD_W(W), .CLEAR_ON_FLUSH(1'b0)) dut_hold (
        .i_clk(i_clk), .i_arst(i_arst), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(b_ready), .i_data(i_data),
        .o_valid(b_valid), .i_ready(i_ready), .o_data(b_data),
        .o_occupancy(b_occ)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare both instances against the model's view: a FIFO holding at most two beats.
    task automatic check_model();
        int n;
        n = model_q.size();
        check("clr_valid", {31'd0, a_valid}, {31'd0, n > 0});
        check("clr_ready", {31'd0, a_ready}, {31'd0, n < 2});
        check("clr_occ", {30'd0, a_occ}, n);
        check("hold_valid", {31'd0, b_valid}, {31'd0, n > 0});
        check("hold_ready", {31'd0, b_ready}, {31'd0, n < 2});
        check("hold_occ", {30'd0, b_occ}, n);
        if (n > 0) begin
            check("clr_data", {24'd0, a_data}, {24'd0, model_q[0]});
            check("hold_data", {24'd0, b_data}, {24'd0, model_q[0]});
        end
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        logic m_in, m_out;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        i_flush = f;
        m_in  = v && (model_q.size() < 2);
        m_out = r && (model_q.size() > 0);
        @(posedge i_clk);
        if (f) begin
            model_q.delete();
        end else begin
            if (m_out) void'(model_q.pop_front());
            if (m_in) model_q.push_back(d);
        end
        @(negedge i_clk);
        check_model();
    endtask

    initial begin
        i_arst  = 1'b1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b0;
        #1;
        check("rst_valid", {31'd0, a_valid}, 32'd0);
        check("rst_ready", {31'd0, a_ready}, 32'd1);
        check("rst_data", {24'd0, a_data}, 32'd0);
        check("rst_occ", {30'd0, a_occ}, 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_arst = 1'b0;
        @(negedge i_clk);
        check_model();

        // Reset asserted mid-stream with two entries held clears outputs immediately.
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        check("pre_rst_occ", {30'd0, a_occ}, 32'd2);
        #2;
        i_arst = 1'b1;
        #1;
        check("arst_valid", {31'd0, a_valid}, 32'd0);
        check("arst_ready", {31'd0, a_ready}, 32'd1);
        check("arst_data", {24'd0, a_data}, 32'd0);
        check("arst_occ", {30'd0, a_occ}, 32'd0);
        check("arst_hold_data", {24'd0, b_data}, 32'd0);
        model_q.delete();
        @(negedge i_clk);
        i_arst = 1'b0;

        // Back-to-back streaming with one cycle latency.
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b1, k[W-1:0], 1'b1, 1'b0);
            check("stream_data", {24'd0, a_data}, k);
            check("stream_ready", {31'd0, a_ready}, 32'd1);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("stream_drained", {31'd0, a_valid}, 32'd0);

        // Stall fills main then skid; release drains in order.
        cycle(1'b1, 8'hA1, 1'b0, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0);
        check("stall_occ", {30'd0, a_occ}, 32'd2);
        check("stall_ready", {31'd0, a_ready}, 32'd0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        check("stall_hold", {24'd0, a_data}, 32'hA1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("release_1", {24'd0, a_data}, 32'hA2);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("release_2", {31'd0, a_valid}, 32'd0);

        // Flush with two held plus a same-cycle offer.
        cycle(1'b1, 8'hB1, 1'b0, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0, 1'b0);
        cycle(1'b1, 8'hB3, 1'b0, 1'b1);
        check("flush_valid", {31'd0, a_valid}, 32'd0);
        check("flush_clr_data", {24'd0, a_data}, 32'h00);
        check("flush_hold_data", {24'd0, b_data}, 32'hB1);
        check("flush_hold_ready", {31'd0, b_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Flush from one held entry discards an accepted same-cycle input.
        cycle(1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b1, 1'b1);
        check("flush_full_valid", {31'd0, a_valid}, 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("flush_full_none", {31'd0, b_valid}, 32'd0);

        // Random traffic with occasional flushes against the queue model.
        for (int k = 0; k < 10000; k++) begin
            cycle(1'($urandom_range(0, 2) != 0), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
